// File: rtl/zet_nmi_hlt_ctrl.sv
// NMI capture/arbitration and HLT wait-state controller for the Zet core.
// Serialises synchronised NMI edges toward decode and produces the halt-aware core stall.
module zet_nmi_hlt_ctrl #(
    parameter int unsigned NMI_CH      = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HLT_TO      = 0,
    parameter int unsigned CNT_W       = 16,
    localparam int unsigned SRC_W      = (NMI_CH > 1) ? $clog2(NMI_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NMI_CH-1:0] nmi_i,
    input  logic [NMI_CH-1:0] nmi_mask,
    input  logic              nmia,
    output logic              nmir,
    output logic [SRC_W-1:0]  nmi_src,
    output logic [NMI_CH-1:0] nmi_pend,
    input  logic              intr,
    input  logic              ifl,
    input  logic              hlt_op,
    input  logic              cpu_block,
    output logic              block_or_hlt,
    output logic              halted,
    output logic [CNT_W-1:0]  halt_cycles,
    output logic              hlt_to
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    localparam bit               TO_EN   = (HLT_TO != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((HLT_TO == 0) ? 0 : HLT_TO - 1);

    logic [SYNC_STAGES-1:0][NMI_CH-1:0] sync_q;
    logic [NMI_CH-1:0] prev_q;
    logic [NMI_CH-1:0] pend_q, pend_d;
    logic [NMI_CH-1:0] rise;
    logic [NMI_CH-1:0] req_vec;
    logic              nmir_q, nmir_d;
    logic              nmia_q;
    logic [SRC_W-1:0]  src_q, src_d, src_low;
    logic              ack, grant;

    state_e            state_q, state_d;
    logic              hlt_op_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hlt_to_q, hlt_to_d;
    logic              wake, to_hit, hlt_in;

    // Synchroniser chain, edge-detect history and registered acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            nmia_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], nmi_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            nmia_q <= nmia;
        end
    end

    assign rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign req_vec = pend_q & ~nmi_mask;
    assign ack     = nmir_q & nmia_q;
    assign grant   = ~nmir_q & ~nmia_q & (|req_vec);

    always_comb begin
        src_low = '0;
        for (int i = int'(NMI_CH) - 1; i >= 0; i--) begin
            if (req_vec[i]) src_low = SRC_W'(i);
        end
    end

    // A fresh edge on the channel being retired keeps that channel pending
    always_comb begin
        pend_d = pend_q | rise;
        nmir_d = nmir_q;
        src_d  = src_q;
        for (int i = 0; i < int'(NMI_CH); i++) begin
            if (ack && (src_q == SRC_W'(i))) pend_d[i] = rise[i];
        end
        if (ack) begin
            nmir_d = 1'b0;
        end else if (grant) begin
            nmir_d = 1'b1;
            src_d  = src_low;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            nmir_q <= 1'b0;
            src_q  <= '0;
        end else begin
            pend_q <= pend_d;
            nmir_q <= nmir_d;
            src_q  <= src_d;
        end
    end

    assign to_hit = TO_EN && (state_q == ST_HALT) && (cnt_q == TO_LAST);
    assign wake   = (intr & ifl) | nmir_q | to_hit;
    assign hlt_in = hlt_op & ~hlt_op_q & ~wake;

    // Halt FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            hlt_op_q <= 1'b0;
            cnt_q    <= '0;
            hlt_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hlt_op_q <= hlt_op;
            cnt_q    <= cnt_d;
            hlt_to_q <= hlt_to_d;
        end
    end

    // Halt FSM next state; the counter is frozen on the exit edge for readout
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hlt_to_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hlt_in) begin
                    state_d = ST_HALT;
                    cnt_d   = '0;
                end
            end
            ST_HALT: begin
                if (wake) begin
                    state_d  = ST_RUN;
                    hlt_to_d = to_hit;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // Stall output: only the bus stall passes through while reset is asserted
    always_comb begin
        block_or_hlt = cpu_block;
        if (!rst && ((state_q == ST_HALT) || hlt_in)) block_or_hlt = 1'b1;
    end

    assign nmir        = nmir_q;
    assign nmi_src     = src_q;
    assign nmi_pend    = pend_q;
    assign halted      = (state_q == ST_HALT);
    assign halt_cycles = cnt_q;
    assign hlt_to      = hlt_to_q;

endmodule

// File: tb/tb_zet_nmi_hlt_ctrl.sv
// Bench for zet_nmi_hlt_ctrl: directed vector table, halt/reset sequences and
// randomized traffic checked against a cycle-level behavioural model.
module tb_zet_nmi_hlt_ctrl;

    localparam int unsigned NMI_CH      = 2;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned HLT_TO      = 24;
    localparam int unsigned CNT_W       = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NMI_CH-1:0] nmi_i;
    logic [NMI_CH-1:0] nmi_mask;
    logic              nmia;
    logic              nmir;
    logic              nmi_src;
    logic [NMI_CH-1:0] nmi_pend;
    logic              intr;
    logic              ifl;
    logic              hlt_op;
    logic              cpu_block;
    logic              block_or_hlt;
    logic              halted;
    logic [CNT_W-1:0]  halt_cycles;
    logic              hlt_to;

    zet_nmi_hlt_ctrl #(
        .NMI_CH      (NMI_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .HLT_TO      (HLT_TO),
        .CNT_W       (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .nmi_i        (nmi_i),
        .nmi_mask     (nmi_mask),
        .nmia         (nmia),
        .nmir         (nmir),
        .nmi_src      (nmi_src),
        .nmi_pend     (nmi_pend),
        .intr         (intr),
        .ifl          (ifl),
        .hlt_op       (hlt_op),
        .cpu_block    (cpu_block),
        .block_or_hlt (block_or_hlt),
        .halted       (halted),
        .halt_cycles  (halt_cycles),
        .hlt_to       (hlt_to)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       hlt_op;
        logic       cpu_block;
        logic [1:0] nmi;
        logic [1:0] mask;
        logic       nmia;
        logic       intr;
        logic       ifl;
    } in_t;

    typedef struct {
        in_t        i;
        bit         chk;
        logic       nmir;
        logic       src;
        logic [1:0] pend;
        logic       blk;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit [NMI_CH-1:0] hist[$];
    bit [NMI_CH-1:0] m_pend = '0;
    bit              m_nmir = 1'b0;
    int              m_src  = 0;
    bit              m_nmia_q = 1'b0;
    bit              m_hop_q  = 1'b0;
    bit              m_halted = 1'b0;
    int              m_cnt    = 0;
    bit              m_hlt_to = 1'b0;

    // Expected values for the cycle just applied
    bit              e_nmir, e_halted, e_hlt_to, e_blk;
    int              e_src, e_cnt;
    bit [NMI_CH-1:0] e_pend;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // A rising input sample becomes pending SYNC_STAGES+1 edges later; the rest
    // follows the request/ack handshake and halt rules one clock at a time.
    task automatic model_step();
        bit [NMI_CH-1:0] rise;
        bit [NMI_CH-1:0] np;
        bit ack, to_hit, wake, hlt_in;
        int low;
        hist.push_front(nmi_i);
        void'(hist.pop_back());
        e_nmir   = m_nmir;
        e_src    = m_src;
        e_pend   = m_pend;
        e_halted = m_halted;
        e_cnt    = m_cnt;
        e_hlt_to = m_hlt_to;
        if (rst) begin
            e_blk = cpu_block;
            foreach (hist[k]) hist[k] = '0;
            m_pend = '0; m_nmir = 1'b0; m_src = 0; m_nmia_q = 1'b0; m_hop_q = 1'b0;
            m_halted = 1'b0; m_cnt = 0; m_hlt_to = 1'b0;
            return;
        end
        rise   = hist[SYNC_STAGES] & ~hist[SYNC_STAGES+1];
        ack    = m_nmir && m_nmia_q;
        to_hit = (HLT_TO != 0) && m_halted && (m_cnt == int'(HLT_TO) - 1);
        wake   = (intr && ifl) || m_nmir || to_hit;
        hlt_in = hlt_op && !m_hop_q && !wake;
        e_blk  = cpu_block || m_halted || hlt_in;

        low = -1;
        for (int k = 0; k < int'(NMI_CH); k++)
            if (low < 0 && m_pend[k] && !nmi_mask[k]) low = k;
        np = m_pend | rise;
        if (ack) np[m_src] = rise[m_src];
        if (ack) m_nmir = 1'b0;
        else if (!m_nmir && !m_nmia_q && low >= 0) begin
            m_nmir = 1'b1;
            m_src  = low;
        end
        m_pend = np;

        m_hlt_to = to_hit;
        if (!m_halted) begin
            if (hlt_in) begin
                m_halted = 1'b1;
                m_cnt    = 0;
            end
        end else if (wake) m_halted = 1'b0;
        else if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        m_nmia_q = nmia;
        m_hop_q  = hlt_op;
    endtask

    task automatic tick(input in_t x);
        @(negedge clk);
        rst = x.rst; hlt_op = x.hlt_op; cpu_block = x.cpu_block; nmi_i = x.nmi;
        nmi_mask = x.mask; nmia = x.nmia; intr = x.intr; ifl = x.ifl;
        #1;
        model_step();
    endtask

    function automatic vec_t mk(input logic r, input logic hop, input logic cb,
                                input logic [1:0] nmi, input logic [1:0] mask, input logic na,
                                input bit chk, input logic enmir, input logic esrc,
                                input logic [1:0] epend, input logic eblk);
        vec_t t;
        t.i.rst = r; t.i.hlt_op = hop; t.i.cpu_block = cb; t.i.nmi = nmi;
        t.i.mask = mask; t.i.nmia = na; t.i.intr = 1'b0; t.i.ifl = 1'b0;
        t.chk = chk; t.nmir = enmir; t.src = esrc; t.pend = epend; t.blk = eblk;
        return t;
    endfunction

    vec_t tbl[$];
    in_t  v;
    in_t  idle;

    initial begin
        rst = 1'b1; hlt_op = 1'b0; cpu_block = 1'b0; nmi_i = '0; nmi_mask = '0;
        nmia = 1'b0; intr = 1'b0; ifl = 1'b0;
        for (int k = 0; k < int'(SYNC_STAGES) + 2; k++) hist.push_back('0);
        idle = '{rst: 1'b0, hlt_op: 1'b0, cpu_block: 1'b0, nmi: 2'b00, mask: 2'b00,
                 nmia: 1'b0, intr: 1'b0, ifl: 1'b0};

        // rst hop cb nmi mask nmia | chk nmir src pend blk
        tbl.push_back(mk(1'b1,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b0, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b1,1'b1,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b10,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b1,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b1));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b10,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1, 1'b1, 1'b1,1'b1,2'b10,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b1,1'b1,2'b10,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b11,2'b00,1'b0, 1'b1, 1'b0,1'b1,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b1,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b1,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b1,2'b11,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1, 1'b1, 1'b1,1'b0,2'b11,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b1,1'b0,2'b11,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b10,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1, 1'b1, 1'b1,1'b1,2'b10,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b1,1'b1,2'b10,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b01,1'b0, 1'b1, 1'b0,1'b1,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b01,1'b0, 1'b1, 1'b0,1'b1,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b01,1'b0, 1'b1, 1'b0,1'b1,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b01,1'b0, 1'b1, 1'b0,1'b1,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b1,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b01,1'b0, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b01,1'b1, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b01,1'b0, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b01,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b1, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b1,1'b0,2'b01,1'b0));
        tbl.push_back(mk(1'b0,1'b0,1'b0,2'b00,2'b00,1'b0, 1'b1, 1'b0,1'b0,2'b00,1'b0));

        foreach (tbl[k]) begin
            tick(tbl[k].i);
            if (tbl[k].chk) begin
                check($sformatf("t%0d_nmir", k), nmir, tbl[k].nmir);
                check($sformatf("t%0d_src", k), nmi_src, tbl[k].src);
                check($sformatf("t%0d_pend", k), nmi_pend, tbl[k].pend);
                check($sformatf("t%0d_blk", k), block_or_hlt, tbl[k].blk);
                check($sformatf("t%0d_halted", k), halted, 1'b0);
            end
        end

        // Halt held off by intr with ifl=0, then released by ifl
        v = idle; v.hlt_op = 1'b1; v.intr = 1'b1;
        tick(v);
        check("h_entry_blk", block_or_hlt, 1'b1);
        check("h_entry_halted", halted, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick(v);
            check($sformatf("h_halted_%0d", k), halted, 1'b1);
            check($sformatf("h_blk_%0d", k), block_or_hlt, 1'b1);
            check($sformatf("h_cnt_%0d", k), halt_cycles, 32'(k - 1));
        end
        v.ifl = 1'b1;
        tick(v);
        check("h_wake_blk", block_or_hlt, 1'b1);
        check("h_wake_cnt", halt_cycles, 32'd20);
        tick(v);
        check("h_run_halted", halted, 1'b0);
        check("h_run_cnt", halt_cycles, 32'd20);
        check("h_run_blk", block_or_hlt, 1'b0);
        v.cpu_block = 1'b1;
        tick(v);
        check("h_cpublk", block_or_hlt, 1'b1);
        v.cpu_block = 1'b0; v.intr = 1'b0; v.ifl = 1'b0;
        tick(v);
        check("h_sustain_blk", block_or_hlt, 1'b0);
        tick(v);
        check("h_sustain_halted", halted, 1'b0);
        v.hlt_op = 1'b0;
        tick(v);

        // Timeout exit after HLT_TO halted cycles
        v = idle; v.hlt_op = 1'b1;
        tick(v);
        check("to_entry_blk", block_or_hlt, 1'b1);
        v.hlt_op = 1'b0;
        for (int k = 1; k <= int'(HLT_TO); k++) begin
            tick(v);
            check($sformatf("to_halted_%0d", k), halted, 1'b1);
            check($sformatf("to_cnt_%0d", k), halt_cycles, 32'(k - 1));
            check($sformatf("to_pulse_%0d", k), hlt_to, 1'b0);
        end
        tick(v);
        check("to_exit_halted", halted, 1'b0);
        check("to_exit_pulse", hlt_to, 1'b1);
        check("to_exit_cnt", halt_cycles, 32'(HLT_TO - 1));
        check("to_exit_blk", block_or_hlt, 1'b0);
        tick(v);
        check("to_pulse_end", hlt_to, 1'b0);

        // HLT while a wake is already present does not halt
        v = idle; v.hlt_op = 1'b1; v.intr = 1'b1; v.ifl = 1'b1;
        tick(v);
        check("nw_blk", block_or_hlt, 1'b0);
        v.hlt_op = 1'b0;
        tick(v);
        check("nw_halted", halted, 1'b0);

        // Reset while halted with both channels pending and a request raised
        v = idle; tick(v);
        v.hlt_op = 1'b1; tick(v);
        v.hlt_op = 1'b0; v.nmi = 2'b11; tick(v);
        check("rh_halted", halted, 1'b1);
        v.nmi = 2'b00; tick(v);
        tick(v);
        tick(v);
        check("rh_pend", nmi_pend, 2'b11);
        check("rh_nmir0", nmir, 1'b0);
        v.rst = 1'b1;
        tick(v);
        check("rh_pre_nmir", nmir, 1'b1);
        check("rh_pre_halted", halted, 1'b1);
        check("rh_pre_cnt", halt_cycles, 32'd4);
        check("rh_rst_blk", block_or_hlt, 1'b0);
        v.rst = 1'b0;
        tick(v);
        check("rh_nmir", nmir, 1'b0);
        check("rh_src", nmi_src, 1'b0);
        check("rh_pend0", nmi_pend, 2'b00);
        check("rh_halted0", halted, 1'b0);
        check("rh_cnt0", halt_cycles, 32'd0);
        check("rh_hlt_to", hlt_to, 1'b0);
        check("rh_blk", block_or_hlt, 1'b0);

        // Randomized traffic against the model
        v = idle; v.rst = 1'b1;
        tick(v);
        tick(v);
        for (int c = 0; c < 4000; c++) begin
            v.rst = ($urandom_range(0, 599) == 0);
            for (int b = 0; b < int'(NMI_CH); b++)
                if ($urandom_range(0, (c < 2000) ? 9 : 199) == 0) v.nmi[b] = ~v.nmi[b];
            if ($urandom_range(0, 29) == 0) v.mask = 2'($urandom_range(0, 3));
            v.nmia = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 11) == 0) v.hlt_op = ~v.hlt_op;
            if ($urandom_range(0, 19) == 0) v.intr = ~v.intr;
            if ($urandom_range(0, 39) == 0) v.ifl = ~v.ifl;
            v.cpu_block = ($urandom_range(0, 4) == 0);
            tick(v);
            check("r_nmir", nmir, e_nmir);
            check("r_src", nmi_src, 32'(e_src));
            check("r_pend", nmi_pend, e_pend);
            check("r_halted", halted, e_halted);
            check("r_cnt", halt_cycles, 32'(e_cnt));
            check("r_hlt_to", hlt_to, e_hlt_to);
            check("r_blk", block_or_hlt, e_blk);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
